// File: rtl/mem_responder.sv
// mem_responder: fixed-latency tagged memory responder.
//
// Accepts one LOAD or STORE per cycle against a DEPTH x 64-bit register
// array, hands out a 4-bit tag (1..15) on acceptance, and answers every
// accepted request exactly LATENCY cycles later, in accept order.
//
// Ports
//   clock    in   single clock, rising edge
//   reset    in   asynchronous active-low reset
//   qry_cmd  in   0=NONE 1=LOAD 2=STORE 3=reserved (acts as NONE)
//   qry_idx  in   block index (address bits 31:3); low log2(DEPTH) bits used
//   qry_blk  in   store data
//   stall    in   blocks acceptance this cycle
//   ack      out  combinational; tag granted this cycle, 0 = not accepted
//   ans_tag  out  registered; tag being answered, 0 = no answer
//   ans_blk  out  registered; answer data (0 when ans_tag is 0)
module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  qry_cmd,
    input  logic [28:0] qry_idx,
    input  logic [63:0] qry_blk,
    input  logic        stall,
    output logic [3:0]  ack,
    output logic [3:0]  ans_tag,
    output logic [63:0] ans_blk
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    // Tag scoreboard; bit 0 is never used because tag 0 means "none".
    logic [15:0] busy_q, busy_d;

    logic [63:0] mem_q [DEPTH];

    // Answer pipeline: stage 0 is loaded at the accepting edge, the last
    // stage drives the outputs. Bubbles carry tag 0 / blk 0 so the outputs
    // come straight from flops.
    logic [LATENCY-1:0]       vld_q;
    logic [LATENCY-1:0][3:0]  tag_q;
    logic [LATENCY-1:0][63:0] blk_q;

    logic          is_req;
    logic          found;
    logic          accept;
    logic [3:0]    free_tag;
    logic [AW-1:0] addr;
    logic [63:0]   rd_blk;
    logic          unused_bits;

    assign addr        = qry_idx[AW-1:0];
    assign unused_bits = ^{qry_idx[28:AW], busy_q[0]};

    // Lowest free tag: scan downward so the last hit wins.
    always_comb begin
        found    = 1'b0;
        free_tag = 4'd0;
        for (int t = 15; t >= 1; t--) begin
            if (!busy_q[t]) begin
                found    = 1'b1;
                free_tag = t[3:0];
            end
        end
    end

    // Gating with reset keeps ack at 0 while reset is held, even though the
    // cleared scoreboard would otherwise offer tag 1.
    assign is_req = (qry_cmd == CMD_LOAD) || (qry_cmd == CMD_STORE);
    assign accept = is_req && !stall && found && reset;
    assign ack    = accept ? free_tag : 4'd0;

    // A STORE answers with its own data; a LOAD samples the array before
    // this edge's write, which cannot target it anyway (one accept per cycle).
    assign rd_blk = (qry_cmd == CMD_STORE) ? qry_blk : mem_q[addr];

    // Release the tag whose answer is on the outputs this cycle, so it is
    // only grantable again from the following cycle.
    always_comb begin
        busy_d = busy_q;
        if (vld_q[LATENCY-1]) begin
            busy_d[tag_q[LATENCY-1]] = 1'b0;
        end
        if (accept) begin
            busy_d[free_tag] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            vld_q  <= '0;
            tag_q  <= '0;
            blk_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            busy_q   <= busy_d;
            vld_q[0] <= accept;
            tag_q[0] <= accept ? free_tag : 4'd0;
            blk_q[0] <= accept ? rd_blk : 64'd0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
                blk_q[i] <= blk_q[i-1];
            end
            if (accept && (qry_cmd == CMD_STORE)) begin
                mem_q[addr] <= qry_blk;
            end
        end
    end

    assign ans_tag = tag_q[LATENCY-1];
    assign ans_blk = blk_q[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int L     = 4;
    localparam int L8    = 8;
    localparam int DEPTH = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  qry_cmd = 2'd0;
    logic [28:0] qry_idx = '0;
    logic [63:0] qry_blk = '0;
    logic        stall = 1'b0;
    logic [3:0]  ack, ans_tag, ack8, ans_tag8;
    logic [63:0] ans_blk, ans_blk8;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(L)) u_dut (
        .clock(clock), .reset(reset), .qry_cmd(qry_cmd), .qry_idx(qry_idx),
        .qry_blk(qry_blk), .stall(stall), .ack(ack), .ans_tag(ans_tag),
        .ans_blk(ans_blk)
    );

    // Second instance at the maximum latency, used for the 8-deep scenario.
    mem_responder #(.DEPTH(DEPTH), .LATENCY(L8)) u_dut8 (
        .clock(clock), .reset(reset), .qry_cmd(qry_cmd), .qry_idx(qry_idx),
        .qry_blk(qry_blk), .stall(stall), .ack(ack8), .ans_tag(ans_tag8),
        .ans_blk(ans_blk8)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] blk;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb8[$];
    logic [63:0] mem_m [DEPTH];
    logic [15:0] bm = '0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          en8 = 1'b0;

    initial forever begin
        @(posedge clock);
        cyc <= cyc + 1;
    end

    // Answer monitor for the main instance.
    initial forever begin
        @(negedge clock);
        if (sb.size() > 0 && sb[0].due < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL ans_missing: tag %0d due at cycle %0d not seen", sb[0].tag, sb[0].due);
            bm[sb[0].tag] = 1'b0;
            void'(sb.pop_front());
        end
        n_tests++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (ans_tag !== sb[0].tag || ans_blk !== sb[0].blk) begin
                n_fail++;
                $display("FAIL ans_main: cycle %0d got tag %0d blk %h, want tag %0d blk %h",
                         cyc, ans_tag, ans_blk, sb[0].tag, sb[0].blk);
            end
            bm[sb[0].tag] = 1'b0;
            void'(sb.pop_front());
        end else if (ans_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL ans_spurious: cycle %0d got tag %0d, want 0", cyc, ans_tag);
        end
    end

    // Answer monitor for the LATENCY=8 instance, only while its scenario runs.
    initial forever begin
        @(negedge clock);
        if (en8) begin
            n_tests++;
            if (sb8.size() > 0 && sb8[0].due == cyc) begin
                if (ans_tag8 !== sb8[0].tag || ans_blk8 !== sb8[0].blk) begin
                    n_fail++;
                    $display("FAIL ans_lat8: cycle %0d got tag %0d blk %h, want tag %0d blk %h",
                             cyc, ans_tag8, ans_blk8, sb8[0].tag, sb8[0].blk);
                end
                void'(sb8.pop_front());
            end else if (ans_tag8 !== 4'd0) begin
                n_fail++;
                $display("FAIL ans_lat8_spurious: cycle %0d got tag %0d, want 0", cyc, ans_tag8);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Drives one cycle of request inputs and predicts the main instance's ack,
    // queueing the expected answer when the request should be accepted.
    task automatic drive_req(input logic [1:0] cmd, input logic [28:0] idx,
                             input logic [63:0] blk, input logic st,
                             output logic [3:0] exp_ack);
        int a;
        bit got;
        qry_cmd = cmd; qry_idx = idx; qry_blk = blk; stall = st;
        exp_ack = 4'd0;
        got = 1'b0;
        if ((cmd == 2'd1 || cmd == 2'd2) && !st) begin
            for (int t = 1; t < 16; t++) begin
                if (!got && !bm[t]) begin
                    got = 1'b1;
                    exp_ack = t[3:0];
                end
            end
        end
        if (got) begin
            bm[exp_ack] = 1'b1;
            a = int'(idx % DEPTH);
            if (cmd == 2'd2) begin
                mem_m[a] = blk;
                sb.push_back('{exp_ack, blk, cyc + L});
            end else begin
                sb.push_back('{exp_ack, mem_m[a], cyc + L});
            end
        end
    endtask

    task automatic idle();
        qry_cmd = 2'd0; stall = 1'b0; qry_idx = '0; qry_blk = '0;
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        sb.delete(); sb8.delete(); bm = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        repeat (hold) next_cycle();
        reset = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) next_cycle();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d answers outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        logic [3:0] e;
        next_cycle();
        drive_req(2'd1, 29'd5, 64'd0, 1'b0, e);
        bm = '0; sb.delete();
        @(negedge clock);
        n_tests++;
        if (ack !== 4'd0) begin n_fail++; $display("FAIL reset_ack: got %0d want 0", ack); end
        n_tests++;
        if (ans_tag !== 4'd0) begin n_fail++; $display("FAIL reset_ans_tag: got %0d want 0", ans_tag); end
        n_tests++;
        if (ans_blk !== 64'd0) begin n_fail++; $display("FAIL reset_ans_blk: got %h want 0", ans_blk); end
        next_cycle();
        idle();
        reset = 1'b1;
    endtask

    task automatic test_single_load();
        logic [3:0] e;
        drive_req(2'd1, 29'd5, 64'd0, 1'b0, e);
        @(negedge clock);
        n_tests++;
        if (ack !== 4'd1) begin n_fail++; $display("FAIL single_ack: got %0d want 1", ack); end
        next_cycle();
        idle();
        drain();
    endtask

    task automatic test_store_load();
        logic [3:0] e;
        drive_req(2'd2, 29'd7, 64'hDEADBEEF_01234567, 1'b0, e);
        @(negedge clock);
        n_tests++;
        if (ack !== 4'd1) begin n_fail++; $display("FAIL store_ack: got %0d want 1", ack); end
        next_cycle();
        drive_req(2'd1, 29'd7, 64'd0, 1'b0, e);
        @(negedge clock);
        n_tests++;
        if (ack !== 4'd2) begin n_fail++; $display("FAIL load_after_store_ack: got %0d want 2", ack); end
        next_cycle();
        idle();
        drain();
    endtask

    task automatic test_stall();
        logic [3:0] e;
        drive_req(2'd1, 29'd9, 64'd0, 1'b0, e);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive_req(2'd1, 29'd9, 64'd0, 1'b1, e);
            @(negedge clock);
            n_tests++;
            if (ack !== 4'd0) begin n_fail++; $display("FAIL stall_ack: cycle %0d got %0d want 0", i, ack); end
            next_cycle();
        end
        // Tag 1 is in its answer cycle here, so it must not be granted yet.
        drive_req(2'd1, 29'd9, 64'd0, 1'b0, e);
        @(negedge clock);
        n_tests++;
        if (ack !== 4'd2) begin n_fail++; $display("FAIL stall_release_ack: got %0d want 2", ack); end
        next_cycle();
        drive_req(2'd3, 29'd9, 64'd0, 1'b0, e);
        @(negedge clock);
        n_tests++;
        if (ack !== 4'd0) begin n_fail++; $display("FAIL reserved_cmd_ack: got %0d want 0", ack); end
        next_cycle();
        idle();
        drain();
    endtask

    task automatic test_alias();
        logic [3:0] e;
        drive_req(2'd2, 29'h40, 64'hAA, 1'b0, e);
        next_cycle();
        drive_req(2'd1, 29'd0, 64'd0, 1'b0, e);
        @(negedge clock);
        n_tests++;
        if (sb.size() == 0 || sb[sb.size()-1].blk !== 64'hAA) begin
            n_fail++; $display("FAIL alias_model: queued load data wrong, want aa");
        end
        n_tests++;
        if (ack !== e) begin n_fail++; $display("FAIL alias_ack: got %0d want %0d", ack, e); end
        next_cycle();
        drive_req(2'd2, 29'h1FFF_FFC3, 64'h1234_5678_9ABC_DEF0, 1'b0, e);
        next_cycle();
        drive_req(2'd1, 29'd3, 64'd0, 1'b0, e);
        next_cycle();
        idle();
        drain();
    endtask

    task automatic test_midflight_reset();
        logic [3:0] e;
        drive_req(2'd1, 29'd7, 64'd0, 1'b0, e);
        next_cycle();
        idle();
        next_cycle();
        do_reset(2);
        drive_req(2'd1, 29'd7, 64'd0, 1'b0, e);
        @(negedge clock);
        n_tests++;
        if (ack !== 4'd1) begin n_fail++; $display("FAIL post_reset_ack: got %0d want 1", ack); end
        n_tests++;
        if (sb.size() != 1 || sb[0].blk !== 64'd0) begin
            n_fail++; $display("FAIL post_reset_model: expected single zero-data answer");
        end
        next_cycle();
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        do_reset(1);
        en8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] want;
            want = (i < 9) ? 4'(i + 1) : 4'd1;
            drive_req(2'd1, 29'(i), 64'd0, 1'b0, e);
            sb8.push_back('{want, 64'd0, cyc + L8});
            @(negedge clock);
            n_tests++;
            if (ack8 !== want) begin
                n_fail++; $display("FAIL b2b_ack: load %0d got %0d want %0d", i, ack8, want);
            end
            next_cycle();
        end
        idle();
        for (int i = 0; i < 30 && sb8.size() > 0; i++) next_cycle();
        n_tests++;
        if (sb8.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: %0d answers outstanding, want 0", sb8.size());
        end
        en8 = 1'b0;
        drain();
    endtask

    task automatic test_random();
        logic [3:0] e;
        for (int i = 0; i < 80; i++) begin
            logic [28:0] idx;
            idx = {27'($urandom_range(0, 3)), 2'b00} << 4 | 29'($urandom_range(0, 7));
            drive_req(2'($urandom_range(0, 3)), idx, {$urandom, $urandom},
                      ($urandom_range(0, 3) == 0), e);
            @(negedge clock);
            n_tests++;
            if (ack !== e) begin
                n_fail++; $display("FAIL rand_ack: step %0d got %0d want %0d", i, ack, e);
            end
            next_cycle();
        end
        idle();
        drain();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        test_reset();
        test_single_load();
        test_store_load();
        test_stall();
        test_alias();
        test_midflight_reset();
        test_back_to_back();
        test_random();
        repeat (3) next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 64-bit blocks in the backing store (power of two).
REQ-002 SHALL have parameter LATENCY, default 4, meaning the cycles from accept to answer, with legal range 1..8.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port qry_cmd, input, 2 bits: 0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE).
REQ-006 SHALL have port qry_idx, input, 29 bits: block index (address bits 31:3).
REQ-007 SHALL have port qry_blk, input, 64 bits: store data.
REQ-008 SHALL have port stall, input, 1 bit: when high, no request is accepted.
REQ-009 SHALL have port ack, output, 4 bits: combinational; nonzero = request accepted this cycle under that tag; 0 = not accepted.
REQ-010 SHALL have port ans_tag, output, 4 bits, registered: nonzero = answer valid for that tag; 0 = no answer.
REQ-011 SHALL have port ans_blk, output, 64 bits, registered: answer data, valid only when ans_tag != 0.

Function
REQ-012 SHALL accept a request in a cycle iff qry_cmd is LOAD or STORE, stall is low, and at least one tag in 1..15 is free.
REQ-013 SHALL drive ack with the lowest-numbered free tag on accept, and 0 otherwise; ack SHALL NOT depend on qry_idx or qry_blk.
REQ-014 SHALL mark the acked tag busy at the accepting clock edge.
REQ-015 SHALL use bits [log2(DEPTH)-1:0] of qry_idx as the array address and ignore upper bits.
REQ-016 On an accepted STORE, SHALL write qry_blk to the array at the accepting edge.
REQ-017 On an accepted LOAD, SHALL capture the array content as of the accepting cycle; a STORE accepted in an earlier cycle is visible, and no store can be accepted in the same cycle.
REQ-018 SHALL present each accepted request on ans_tag/ans_blk exactly LATENCY cycles after the accepting edge, for exactly one cycle.
REQ-019 A LOAD answer SHALL carry the captured block; a STORE answer SHALL carry the stored block.
REQ-020 SHALL deliver answers in accept order, holding at most one answer per cycle.
REQ-021 SHALL free the answered tag at the edge ending its answer cycle, so the tag may be re-acked in the following cycle; it is not re-acked in the answer cycle itself.
REQ-022 SHALL keep the internal pipeline of depth LATENCY, with each stage holding {valid, tag, blk}; empty stages give ans_tag = 0.
REQ-023 Stall or an idle cycle SHALL insert a bubble; in-flight requests SHALL continue to advance regardless of stall.
REQ-024 With LATENCY ≤ 8 and one accept per cycle, busy tags SHALL never exceed 8; the no-free-tag path SHALL still be implemented and SHALL give ack = 0.

Reset
REQ-025 While reset is low, SHALL clear all tags to free, all pipeline stages to invalid, and all array blocks to 0, asynchronously.
REQ-026 During reset, SHALL drive ack = 0, ans_tag = 0 and ans_blk = 0.
REQ-027 A reset asserted mid-operation SHALL discard in-flight requests with no answer produced after reset is released.
REQ-028 SHALL allow the first accept in the first cycle after reset release, with ack = 1.

Verification
REQ-029 Scenario single load: after reset, LOAD idx=5 -> ack=1 that cycle; 4 cycles later ans_tag=1 and ans_blk=0; then ans_tag=0.
REQ-030 Scenario store then load: STORE idx=7 blk=0xDEADBEEF_01234567 (ack=1), next cycle LOAD idx=7 (ack=2) -> ans_tag=1 then ans_tag=2 on consecutive cycles, both with blk=0xDEADBEEF_01234567.
REQ-031 Scenario back-to-back: 8 consecutive LOADs -> acks 1..8; answers tags 1..8 in order; tag 1 re-acked one cycle after its answer cycle.
REQ-032 Scenario stall: qry_cmd=LOAD with stall=1 for 3 cycles -> ack=0 and no answer; on release, ack = lowest free tag.
REQ-033 Scenario alias and reset: STORE idx=0x40 blk=0xAA (DEPTH=64), then LOAD idx=0 -> answer 0xAA; a LOAD issued, then reset pulsed 2 cycles later -> no answer ever appears, and the next accept gets ack=1 with blk=0.
